// File: rtl/vx_wb_pkg.sv
// vx_wb_pkg: shared definitions for the writeback arbiter slice.
//   - Lane count, warp count and register index width fix the packet layout.
//   - WID_W is the warp id width (at least 1 bit).
//   - CMT_* name the commit inputs in their arbitration order.
//   - wb_pkt_t is one buffered writeback beat.
package vx_wb_pkg;

  localparam int NUM_CMT     = 5;
  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int NR_BITS     = 5;
  localparam int WB_DEPTH    = 2;
  localparam int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  localparam int CMT_ALU = 0;
  localparam int CMT_LD  = 1;
  localparam int CMT_CSR = 2;
  localparam int CMT_FPU = 3;
  localparam int CMT_GPU = 4;

  typedef struct packed {
    logic [WID_W-1:0]          wid;
    logic [31:0]               pc;
    logic [NUM_THREADS-1:0]    tmask;
    logic [NR_BITS-1:0]        rd;
    logic                      eop;
    logic [NUM_THREADS*32-1:0] data;
  } wb_pkt_t;

endpackage

// File: rtl/vx_rr_lock_arb.sv
// vx_rr_lock_arb: round-robin arbiter with packet locking.
// Ports:
//   clk, reset       core clock, asynchronous active-low reset
//   req              request per input
//   accept           the current grant was taken this cycle (implies grant_valid)
//   accept_eop       the accepted beat ends its packet
//   grant_valid/idx  combinational grant
//   locked/lock_idx  current lock state, exposed for readiness and statistics
// Unlocked, the first requester at or after the pointer wins. Locked, only the
// locked input can win. A non-final accepted beat locks onto its input; a final
// beat unlocks and moves the pointer one past the winner.
module vx_rr_lock_arb #(
  parameter  int NUM_REQS = 5,
  localparam int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                accept,
  input  logic                accept_eop,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                locked,
  output logic [IDX_W-1:0]    lock_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] scan_idx;

  // Cyclic index add, modulo NUM_REQS.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'({1'b0, base}) + off;
    if (sum >= NUM_REQS) sum = sum - NUM_REQS;
    return IDX_W'(sum);
  endfunction

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    if (locked) begin
      grant_valid = req[lock_idx];
      grant_idx   = lock_idx;
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        scan_idx = wrap_add(ptr, k);
        if (req[scan_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = scan_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (accept) begin
      if (accept_eop) begin
        locked <= 1'b0;
        ptr    <= wrap_add(grant_idx, 1);
      end else begin
        locked   <= 1'b1;
        lock_idx <= grant_idx;
      end
    end
  end

endmodule

// File: rtl/vx_writeback_arb.sv
// vx_writeback_arb: merges per-unit commit streams into the register-file
// writeback port through a small output FIFO.
// Ports:
//   clk, reset      core clock, asynchronous active-low reset
//   cmt_*           flattened per-input commit packets (input i in slice i)
//   cmt_ready       per-input accept
//   wb_*            writeback beat from the FIFO head, zero while empty
//   wb_ready        register file accepts
//   perf_*          stall/conflict counters, only with VX_WB_PERF_EN defined
// Lane count, warp id width and register index width come from vx_wb_pkg.
// Non-writing commits are accepted immediately and never reach the FIFO.
module vx_writeback_arb
  import vx_wb_pkg::*;
#(
  parameter int NUM_REQS = NUM_CMT,
  parameter int DEPTH    = WB_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             cmt_valid,
  input  logic [NUM_REQS*WID_W-1:0]       cmt_wid,
  input  logic [NUM_REQS*32-1:0]          cmt_pc,
  input  logic [NUM_REQS*NUM_THREADS-1:0] cmt_tmask,
  input  logic [NUM_REQS*NR_BITS-1:0]     cmt_rd,
  input  logic [NUM_REQS-1:0]             cmt_wb,
  input  logic [NUM_REQS-1:0]             cmt_eop,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0] cmt_data,
  output logic [NUM_REQS-1:0]             cmt_ready,
  output logic                            wb_valid,
  output logic [WID_W-1:0]                wb_wid,
  output logic [31:0]                     wb_pc,
  output logic [NUM_THREADS-1:0]          wb_tmask,
  output logic [NR_BITS-1:0]              wb_rd,
  output logic                            wb_eop,
  output logic [NUM_THREADS*32-1:0]       wb_data,
  input  logic                            wb_ready
`ifdef VX_WB_PERF_EN
  ,
  output logic [63:0]                     perf_stall_cycles,
  output logic [63:0]                     perf_conflicts
`endif
);

  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_pkt_t             in_pkt [NUM_REQS];
  wb_pkt_t             mem    [DEPTH];
  wb_pkt_t             head;
  logic [NUM_REQS-1:0] cand, drop;
  logic                grant_valid, arb_locked;
  logic [IDX_W-1:0]    grant_idx, arb_lock_idx;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                full, push, pop;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
    assign in_pkt[g] = {cmt_wid[g*WID_W +: WID_W], cmt_pc[g*32 +: 32],
                        cmt_tmask[g*NUM_THREADS +: NUM_THREADS], cmt_rd[g*NR_BITS +: NR_BITS],
                        cmt_eop[g], cmt_data[g*NUM_THREADS*32 +: NUM_THREADS*32]};
  end

  assign cand = cmt_valid & cmt_wb;
  assign drop = cmt_valid & ~cmt_wb;
  assign full = (count == CNT_W'(DEPTH));
  assign push = grant_valid & ~full;
  assign pop  = wb_valid & wb_ready;

  vx_rr_lock_arb #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (cand),
    .accept      (push),
    .accept_eop  (cmt_eop[grant_idx]),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .locked      (arb_locked),
    .lock_idx    (arb_lock_idx)
  );

  // An idle input reports ready when a writing packet from it could be taken
  // right now (buffer has room and the lock does not exclude it).
  always_comb begin
    cmt_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cmt_ready[i] = drop[i]
                   | (cand[i] & push & (int'(grant_idx) == i))
                   | (~cmt_valid[i] & ~full & (~arb_locked | (int'(arb_lock_idx) == i)));
    end
  end

  // FIFO storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_pkt[grant_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wb_valid = (count != '0);
  assign head     = wb_valid ? mem[rd_ptr] : '0;
  assign wb_wid   = head.wid;
  assign wb_pc    = head.pc;
  assign wb_tmask = head.tmask;
  assign wb_rd    = head.rd;
  assign wb_eop   = head.eop;
  assign wb_data  = head.data;

`ifdef VX_WB_PERF_EN
  logic [NUM_REQS-1:0] lock_mask;
  logic                conflict;

  assign lock_mask = NUM_REQS'(1) << arb_lock_idx;
  assign conflict  = ($countones(cand) >= 2) | (arb_locked & (|(cand & ~lock_mask)));

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_conflicts    <= '0;
    end else begin
      if (wb_valid && !wb_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 64'd1;
      if (conflict && perf_conflicts != '1)
        perf_conflicts <= perf_conflicts + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_writeback_arb.sv
// tb_vx_writeback_arb: self-checking bench for vx_writeback_arb.
// A queue-based reference model tracks the expected FIFO contents and the
// round-robin/lock state; table vectors and directed sequences add
// hand-derived expectations on top of it.
module tb_vx_writeback_arb;
  import vx_wb_pkg::*;

  localparam int NR = NUM_CMT;
  localparam int NT = NUM_THREADS;
  localparam int DP = WB_DEPTH;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NR-1:0]           cmt_valid, cmt_wb, cmt_eop, cmt_ready;
  logic [NR*WID_W-1:0]     cmt_wid;
  logic [NR*32-1:0]        cmt_pc;
  logic [NR*NT-1:0]        cmt_tmask;
  logic [NR*NR_BITS-1:0]   cmt_rd;
  logic [NR*NT*32-1:0]     cmt_data;
  logic                    wb_valid, wb_eop, wb_ready;
  logic [WID_W-1:0]        wb_wid;
  logic [31:0]             wb_pc;
  logic [NT-1:0]           wb_tmask;
  logic [NR_BITS-1:0]      wb_rd;
  logic [NT*32-1:0]        wb_data;
`ifdef VX_WB_PERF_EN
  logic [63:0]             perf_stall_cycles, perf_conflicts;
`endif

  always #5 clk = ~clk;

  vx_writeback_arb dut (
    .clk       (clk),
    .reset     (reset),
    .cmt_valid (cmt_valid),
    .cmt_wid   (cmt_wid),
    .cmt_pc    (cmt_pc),
    .cmt_tmask (cmt_tmask),
    .cmt_rd    (cmt_rd),
    .cmt_wb    (cmt_wb),
    .cmt_eop   (cmt_eop),
    .cmt_data  (cmt_data),
    .cmt_ready (cmt_ready),
    .wb_valid  (wb_valid),
    .wb_wid    (wb_wid),
    .wb_pc     (wb_pc),
    .wb_tmask  (wb_tmask),
    .wb_rd     (wb_rd),
    .wb_eop    (wb_eop),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready)
`ifdef VX_WB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_conflicts    (perf_conflicts)
`endif
  );

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // Reference model state.
  int      m_ptr;
  bit      m_locked;
  int      m_lidx;
  wb_pkt_t m_q[$];
  wb_pkt_t drv_pkt[NR];

  typedef struct {
    logic [NR-1:0] v, w, e;
    logic          r;
    logic [NR-1:0] rdy;
    logic          wbv;
    logic [3:0]    src;
  } vec_t;
  vec_t tbl[12];

  task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (m_q.size() >= DP) return -1;
    if (m_locked) return (cmt_valid[m_lidx] && cmt_wb[m_lidx]) ? m_lidx : -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (cmt_valid[i] && cmt_wb[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ptr    = 0;
    m_locked = 0;
    m_lidx   = 0;
  endtask

  // Drive one cycle of commit traffic at the falling edge, check the DUT
  // against the model, then advance the model to the next rising edge.
  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] w,
                               input logic [NR-1:0] e, input logic r);
    wb_pkt_t       p;
    int            g;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    cyc++;
    cmt_valid = v;
    cmt_wb    = w;
    cmt_eop   = e;
    wb_ready  = r;
    for (int i = 0; i < NR; i++) begin
      p.wid   = WID_W'($urandom);
      p.pc    = {4'(i), 28'(cyc)};
      p.tmask = NT'($urandom);
      p.rd    = NR_BITS'($urandom);
      p.eop   = e[i];
      for (int l = 0; l < NT; l++) p.data[l*32 +: 32] = $urandom;
      drv_pkt[i] = p;
      cmt_wid[i*WID_W +: WID_W]     = p.wid;
      cmt_pc[i*32 +: 32]            = p.pc;
      cmt_tmask[i*NT +: NT]         = p.tmask;
      cmt_rd[i*NR_BITS +: NR_BITS]  = p.rd;
      cmt_data[i*NT*32 +: NT*32]    = p.data;
    end
    #1;
    checkOutput("wb_valid", wb_valid, m_q.size() != 0);
    if (m_q.size() != 0)
      checkOutput("wb_pkt", {wb_wid, wb_pc, wb_tmask, wb_rd, wb_eop, wb_data}, m_q[0]);
    g = model_grant();
    for (int i = 0; i < NR; i++)
      exp_rdy[i] = (v[i] && !w[i]) || (i == g) ||
                   (!v[i] && m_q.size() < DP && (!m_locked || m_lidx == i));
    checkOutput("cmt_ready", cmt_ready & v, exp_rdy & v);
    if (m_q.size() != 0 && r) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(drv_pkt[g]);
      if (e[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % NR;
      end else begin
        m_locked = 1;
        m_lidx   = g;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b0;
    cmt_valid = '0;
    cmt_wb    = '0;
    cmt_eop   = '0;
    wb_ready  = 1'b1;
    model_reset();
    #1;
    checkOutput("rst_async_valid", wb_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_wb_valid", wb_valid, 1'b0);
    checkOutput("rst_wb_fields", {wb_wid, wb_pc, wb_tmask, wb_rd, wb_eop, wb_data}, '0);
    reset = 1'b1;
    #1;
    checkOutput("rst_idle_ready", cmt_ready, {NR{1'b1}});
  endtask

  initial begin
    int       acc, seen;
    logic [31:0] hold_pc;

    reset     = 1'b0;
    cmt_valid = '0;
    cmt_wb    = '0;
    cmt_eop   = '0;
    cmt_wid   = '0;
    cmt_pc    = '0;
    cmt_tmask = '0;
    cmt_rd    = '0;
    cmt_data  = '0;
    wb_ready  = 1'b1;

    //            valid     wb        eop       rdy  exp_ready wbv  src
    tbl[0]  = '{5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b01011, 1'b0, 4'h0};
    tbl[1]  = '{5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b01110, 1'b1, 4'h0};
    tbl[2]  = '{5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b11010, 1'b1, 4'h2};
    tbl[3]  = '{5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b01011, 1'b1, 4'h4};
    tbl[4]  = '{5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b01110, 1'b1, 4'h0};
    tbl[5]  = '{5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b11111, 1'b1, 4'h2};
    tbl[6]  = '{5'b00011, 5'b00011, 5'b00001, 1'b1, 5'b11110, 1'b1, 4'h0};
    tbl[7]  = '{5'b00011, 5'b00011, 5'b00001, 1'b1, 5'b00010, 1'b1, 4'h1};
    tbl[8]  = '{5'b00011, 5'b00011, 5'b00011, 1'b1, 5'b00010, 1'b1, 4'h1};
    tbl[9]  = '{5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b11111, 1'b1, 4'h1};
    tbl[10] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b11111, 1'b1, 4'h0};
    tbl[11] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b11111, 1'b0, 4'h0};

    doReset();

    // Round-robin contention, then a three-beat locked packet on input 1.
    for (int t = 0; t < 12; t++) begin
      applyStimulus(tbl[t].v, tbl[t].w, tbl[t].e, tbl[t].r);
      checkOutput("tbl_ready", cmt_ready & tbl[t].v, tbl[t].rdy & tbl[t].v);
      checkOutput("tbl_wb_valid", wb_valid, tbl[t].wbv);
      if (tbl[t].wbv) checkOutput("tbl_wb_src", wb_pc[31:28], tbl[t].src);
    end

    // Backpressure on a streaming input, with a drop while the buffer is full.
    acc     = 0;
    hold_pc = '0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus((k == 3) ? 5'b01100 : 5'b01000, 5'b01000, 5'b01000, 1'b0);
      if (cmt_ready[3]) acc++;
      if (k == 1) hold_pc = wb_pc;
      if (k >= 2) checkOutput("bp_hold_pc", wb_pc, hold_pc);
      if (k == 3) checkOutput("drop_full_ready", cmt_ready[2], 1'b1);
    end
    checkOutput("bp_accepted", acc, DP);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
      if (wb_valid) seen++;
    end
    checkOutput("drain_count", seen, DP);

    // Reset while locked onto input 1 mid-packet.
    applyStimulus(5'b00010, 5'b00010, 5'b00000, 1'b1);
    checkOutput("lock_grant", cmt_ready[1], 1'b1);
    applyStimulus(5'b00011, 5'b00011, 5'b00000, 1'b1);
    checkOutput("lock_hold", cmt_ready[1:0], 2'b10);
    doReset();
    applyStimulus(5'b00011, 5'b00011, 5'b00011, 1'b1);
    checkOutput("post_reset_grant", cmt_ready[1:0], 2'b01);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(NR'($urandom), NR'($urandom | $urandom), NR'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
